// File: rtl/axi_sram_responder.sv
// AXI3 slave backed by a single-port synchronous SRAM; one transaction in flight,
// round-robin arbitration between read and write requests.
module axi_sram_responder #(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            arid,
    input  logic [31:0]           araddr,
    input  logic [3:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [3:0]            rid,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [3:0]            awid,
    input  logic [31:0]           awaddr,
    input  logic [3:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wlast,
    input  logic [3:0]            wid,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [3:0]            bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    output logic                  sram_en,
    output logic [3:0]            sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_CAP,
        RD_RESP,
        WR_DATA,
        WR_RESP
    } state_t;

    typedef enum logic {
        GRANT_READ,
        GRANT_WRITE
    } grant_t;

    state_t      state;
    grant_t      last_grant;
    logic [31:0] cur_addr;
    logic [3:0]  cur_len;
    logic [2:0]  cur_size;
    logic [1:0]  cur_burst;
    logic [3:0]  beat;
    logic        read_grant;
    logic        write_grant;
    logic        wr_beat;
    logic [31:0] addr_next;
    logic        unused_inputs;

    function automatic logic [31:0] next_addr(
        input logic [31:0] addr,
        input logic [2:0]  size,
        input logic [3:0]  len,
        input logic [1:0]  burst
    );
        logic [31:0] incr;
        logic [31:0] mask;
        logic        wrap_ok;
        logic [31:0] result;
        incr    = 32'd1 << size;
        mask    = (({28'd0, len} + 32'd1) * incr) - 32'd1;
        wrap_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        case (burst)
            2'b00:   result = addr;
            2'b10:   result = wrap_ok ? ((addr & ~mask) | ((addr + incr) & mask)) : (addr + incr);
            default: result = addr + incr;
        endcase
        return result;
    endfunction

    // Grants are suppressed while reset is held so no handshake is lost to it.
    assign read_grant  = (state == IDLE) && !reset && arvalid &&
                         (!awvalid || (last_grant == GRANT_WRITE));
    assign write_grant = (state == IDLE) && !reset && awvalid && !read_grant;
    assign arready     = read_grant;
    assign awready     = write_grant;
    assign wr_beat     = (state == WR_DATA) && wvalid && !reset;
    assign addr_next   = next_addr(cur_addr, cur_size, cur_len, cur_burst);

    assign rresp      = '0;
    assign bresp      = '0;
    assign sram_addr  = cur_addr[ADDR_WIDTH+1:2];
    assign sram_wdata = wdata;

    assign unused_inputs = ^{wid, wlast, cur_addr[31:ADDR_WIDTH+2], cur_addr[1:0]};

    always_comb begin
        sram_en  = 1'b0;
        sram_wen = '0;
        if (!reset && (state == RD_ADDR)) begin
            sram_en = 1'b1;
        end else if (wr_beat) begin
            sram_en  = 1'b1;
            sram_wen = wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GRANT_WRITE;
            cur_addr   <= '0;
            cur_len    <= '0;
            cur_size   <= '0;
            cur_burst  <= '0;
            beat       <= '0;
            rvalid     <= 1'b0;
            rlast      <= 1'b0;
            rdata      <= '0;
            rid        <= '0;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
            bid        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (read_grant) begin
                        last_grant <= GRANT_READ;
                        rid        <= arid;
                        cur_addr   <= araddr;
                        cur_len    <= arlen;
                        cur_size   <= arsize;
                        cur_burst  <= arburst;
                        beat       <= '0;
                        state      <= RD_ADDR;
                    end else if (write_grant) begin
                        last_grant <= GRANT_WRITE;
                        bid        <= awid;
                        cur_addr   <= awaddr;
                        cur_len    <= awlen;
                        cur_size   <= awsize;
                        cur_burst  <= awburst;
                        beat       <= '0;
                        wready     <= 1'b1;
                        state      <= WR_DATA;
                    end
                end
                RD_ADDR: state <= RD_CAP;
                RD_CAP: begin
                    rdata  <= sram_rdata;
                    rvalid <= 1'b1;
                    rlast  <= (beat == cur_len);
                    state  <= RD_RESP;
                end
                RD_RESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        if (rlast) begin
                            state <= IDLE;
                        end else begin
                            cur_addr <= addr_next;
                            beat     <= beat + 4'd1;
                            state    <= RD_ADDR;
                        end
                    end
                end
                WR_DATA: begin
                    if (wvalid) begin
                        cur_addr <= addr_next;
                        beat     <= beat + 4'd1;
                        if (beat == cur_len) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            state  <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder with a behavioural one-cycle-latency SRAM.
module tb_axi_sram_responder;

    logic        clk;
    logic        reset;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic [3:0]  wid;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    logic        pl_en;
    logic [15:0] pl_addr;
    logic [31:0] pl_data;
    logic [31:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    axi_sram_responder #(.ADDR_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wid(wid),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM; the bench preloads through pl_* so mem has one writer.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (sram_en) begin
            if (sram_wen == 4'b0000) begin
                sram_rdata <= mem[sram_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wen[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        step();
        pl_en   = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        arid = id; araddr = a; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        #1;
        check("arready_on_ar", arready, 1);
        step();
        arvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst;
        awvalid = 1'b1;
        #1;
        check("awready_on_aw", awready, 1);
        step();
        awvalid = 1'b0;
    endtask

    task automatic wait_rvalid();
        for (int i = 0; i < 20 && !rvalid; i++) step();
        check("rvalid_within_budget", rvalid, 1);
    endtask

    task automatic wait_sram_en();
        for (int i = 0; i < 20 && !sram_en; i++) step();
        check("sram_en_within_budget", sram_en, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        logic        got_grant;

        reset = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wid = '0; wvalid = 1'b0;
        bready = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        step(); step(); step();

        check("rst_arready", arready, 0);
        check("rst_awready", awready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_sram_en", sram_en, 0);
        check("rst_sram_wen", sram_wen, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rid", rid, 0);
        check("rst_bid", bid, 0);
        reset = 1'b0;

        // Single read: data appears three cycles after the AR handshake.
        preload(16'h0040, 32'hDEADBEEF);
        send_ar(4'd3, 32'h100, 4'd0, 3'd2, 2'b01);
        check("single_rd_sram_en", sram_en, 1);
        check("single_rd_sram_wen", sram_wen, 0);
        check("single_rd_sram_addr", sram_addr, 32'h40);
        step();
        check("single_rd_no_early_rvalid", rvalid, 0);
        step();
        check("single_rd_rvalid", rvalid, 1);
        check("single_rd_rdata", rdata, 32'hDEADBEEF);
        check("single_rd_rid", rid, 3);
        check("single_rd_rlast", rlast, 1);
        check("single_rd_rresp", rresp, 0);
        rready = 1'b1;
        step();
        rready = 1'b0;
        check("single_rd_done", rvalid, 0);

        // INCR read with two stall cycles on beat 1.
        for (int i = 0; i < 4; i++) preload(16'h0080 + 16'(i), 32'hA000_0000 + 32'(i));
        send_ar(4'd1, 32'h200, 4'd3, 3'd2, 2'b01);
        for (int b = 0; b < 4; b++) begin
            wait_rvalid();
            check("incr_rdata", rdata, 32'hA000_0000 + 32'(b));
            check("incr_rlast", rlast, 32'(b == 3));
            check("incr_rid", rid, 1);
            if (b == 1) begin
                held = rdata;
                for (int s = 0; s < 2; s++) begin
                    step();
                    check("stall_rvalid", rvalid, 1);
                    check("stall_rdata", rdata, held);
                end
            end
            rready = 1'b1;
            step();
            rready = 1'b0;
        end

        // Byte-strobe write.
        preload(16'h0010, 32'h11223344);
        send_aw(4'd5, 32'h40, 4'd0, 3'd2, 2'b01);
        check("wr_wready", wready, 1);
        wvalid = 1'b1; wdata = 32'hAABBCCDD; wstrb = 4'b0101;
        #1;
        check("wr_sram_en", sram_en, 1);
        check("wr_sram_wen", sram_wen, 4'b0101);
        check("wr_sram_addr", sram_addr, 32'h10);
        step();
        wvalid = 1'b0;
        check("wr_bvalid", bvalid, 1);
        check("wr_bid", bid, 5);
        check("wr_bresp", bresp, 0);
        check("wr_wready_low", wready, 0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("wr_bvalid_done", bvalid, 0);
        check("wr_mem", mem[16'h0010], 32'h11BB33DD);

        // WRAP read: word addresses 14, 15, 12, 13.
        for (int i = 12; i < 16; i++) preload(16'(i), 32'hC000_0000 + 32'(i));
        send_ar(4'd2, 32'h38, 4'd3, 3'd2, 2'b10);
        rready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            logic [15:0] exp_idx;
            case (b)
                0: exp_idx = 16'd14;
                1: exp_idx = 16'd15;
                2: exp_idx = 16'd12;
                default: exp_idx = 16'd13;
            endcase
            wait_sram_en();
            check("wrap_sram_addr", sram_addr, exp_idx);
            wait_rvalid();
            check("wrap_rdata", rdata, 32'hC000_0000 + 32'(exp_idx));
            check("wrap_rlast", rlast, 32'(b == 3));
            step();
        end
        rready = 1'b0;

        // Arbitration: both requests held from reset alternate, read first.
        reset = 1'b1;
        arid = 4'd4; araddr = 32'h100; arlen = '0; arsize = 3'd2; arburst = 2'b01;
        awid = 4'd6; awaddr = 32'h300; awlen = '0; awsize = 3'd2; awburst = 2'b01;
        wdata = 32'h0000_0055; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1; rready = 1'b1; bready = 1'b1;
        step(); step();
        check("arb_arready_in_reset", arready, 0);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            got_grant = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (arready || awready) begin
                    got_grant = 1'b1;
                    break;
                end
                step();
            end
            check("arb_grant_within_budget", got_grant, 1);
            check("arb_arready", arready, 32'(k % 2 == 0));
            check("arb_awready", awready, 32'(k % 2 == 1));
            step();
        end
        arvalid = 1'b0; awvalid = 1'b0;
        for (int i = 0; i < 20 && !bvalid; i++) step();
        check("arb_last_bvalid", bvalid, 1);
        step();
        wvalid = 1'b0; rready = 1'b0; bready = 1'b0;

        // Reset during beat 2 of an 8-beat write.
        send_aw(4'd2, 32'h400, 4'd7, 3'd2, 2'b01);
        wvalid = 1'b1; wstrb = 4'hF; wdata = 32'h0B00_0000;
        step();
        wdata = 32'h0B00_0001;
        step();
        wdata = 32'h0B00_0002;
        reset = 1'b1;
        step();
        reset = 1'b0;
        wvalid = 1'b0;
        check("mid_rst_wready", wready, 0);
        check("mid_rst_bvalid", bvalid, 0);
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_awready", awready, 0);
        check("mid_rst_arready", arready, 0);
        check("mid_rst_beat0_mem", mem[16'h0100], 32'h0B00_0000);
        check("mid_rst_beat1_mem", mem[16'h0101], 32'h0B00_0001);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_rst_no_bvalid", bvalid, 0);
        end
        send_ar(4'd7, 32'h100, 4'd0, 3'd2, 2'b01);
        wait_rvalid();
        check("post_rst_rdata", rdata, 32'hDEADBEEF);
        check("post_rst_rid", rid, 7);
        check("post_rst_rlast", rlast, 1);
        rready = 1'b1;
        step();
        rready = 1'b0;
        check("post_rst_done", rvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
